// File: rtl/pconv_accum.sv
// pconv_accum: accumulates NUM_PCONV signed partial sums plus bias, then rounds, shifts, applies ReLU and saturates to unsigned.
module pconv_accum #(
    parameter int PCONV_LEN = 18,
    parameter int NUM_PCONV = 3,
    parameter int BIAS_LEN  = 16,
    parameter int ACC_LEN   = 21,
    parameter int OUT_LEN   = 8,
    parameter int SHIFT_LEN = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [PCONV_LEN-1:0] i_pconv,
    input  logic [BIAS_LEN-1:0]  i_bias,
    input  logic [SHIFT_LEN-1:0] i_shift,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_LEN-1:0]   o_data,
    output logic                 o_sat
);
    typedef enum logic {S_ACC, S_OUT} state_t;
    localparam int CNT_W = NUM_PCONV > 1 ? $clog2(NUM_PCONV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PCONV - 1);
    localparam logic signed [ACC_LEN:0] MAXV = (ACC_LEN+1)'((1 << OUT_LEN) - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic signed [ACC_LEN-1:0] acc;
    logic [SHIFT_LEN-1:0] shift_q, sh;
    logic accept, first, last;
    logic signed [ACC_LEN:0] bias_x, pconv_x, acc_x, sum, half, rnd, q;
    assign first   = cnt == '0;
    assign last    = cnt == LAST;
    assign accept  = i_valid && o_ready;
    assign sh      = first ? i_shift : shift_q;
    assign bias_x  = {{(ACC_LEN+1-BIAS_LEN){i_bias[BIAS_LEN-1]}}, i_bias};
    assign pconv_x = {{(ACC_LEN+1-PCONV_LEN){i_pconv[PCONV_LEN-1]}}, i_pconv};
    assign acc_x   = {acc[ACC_LEN-1], acc};
    assign sum     = (first ? bias_x : acc_x) + pconv_x;
    assign half    = sh == '0 ? '0 : (ACC_LEN+1)'(1) << (sh - 1'b1);
    assign rnd     = sum + half;
    assign q       = rnd >>> sh;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_ACC;
        else          state <= state_n;
    end
    always_comb begin
        state_n = (accept && last) ? S_OUT : (state == S_OUT && !i_ready) ? S_OUT : S_ACC;
    end
    always_comb begin
        o_ready = state == S_ACC || i_ready;
        o_valid = state == S_OUT;
    end
    // A beat accepted while retiring a result starts the next group.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            shift_q <= '0;
            o_data  <= '0;
            o_sat   <= 1'b0;
        end else if (accept) begin
            if (first) shift_q <= i_shift;
            if (last) begin
                cnt    <= '0;
                o_data <= q < 0 ? '0 : q > MAXV ? {OUT_LEN{1'b1}} : q[OUT_LEN-1:0];
                o_sat  <= q > MAXV;
            end else begin
                cnt <= cnt + 1'b1;
                acc <= sum[ACC_LEN-1:0];
            end
        end
    end
endmodule
